// File: rtl/tron_game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tron_game_pkg
// Description : Shared game state and screen encodings, plus the keyboard
//               keycode constants used by the Tron match controller.
// Revision    : 1.0 - initial release
// ============================================================================
package tron_game_pkg;

    typedef enum logic [2:0] {
        MENU          = 3'd0,
        ROUND_PAUSED  = 3'd1,
        ROUND_STARTED = 3'd2,
        ROUND_OVER    = 3'd3,
        MATCH_OVER    = 3'd4
    } game_state_t;

    typedef enum logic [2:0] {
        SCR_MENU         = 3'd0,
        SCR_MAP          = 3'd1,
        SCR_ROUND_RESULT = 3'd2,
        SCR_MATCH_RESULT = 3'd3
    } screen_t;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;

    // Paused and running rounds share the map backdrop.
    function automatic screen_t screen_of(input game_state_t st);
        case (st)
            ROUND_PAUSED,
            ROUND_STARTED: screen_of = SCR_MAP;
            ROUND_OVER:    screen_of = SCR_ROUND_RESULT;
            MATCH_OVER:    screen_of = SCR_MATCH_RESULT;
            default:       screen_of = SCR_MENU;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_press_detect.sv
`default_nettype none
// ============================================================================
// Module      : key_press_detect
// Description : Registers the previous keycode and emits one-cycle press
//               strobes for ENTER, UP and DOWN; a held key fires only once.
// Revision    : 1.0 - initial release
// ============================================================================
module key_press_detect
    import tron_game_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Reset_Game,
    input  logic [7:0] keycode,
    output logic       enter_o,
    output logic       up_o,
    output logic       down_o
);

    logic [7:0] prev_key_q;
    logic       new_key;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prev_key_q <= 8'h00;
        end else if (Reset_Game) begin
            prev_key_q <= 8'h00;
        end else begin
            prev_key_q <= keycode;
        end
    end

    assign new_key = (keycode != prev_key_q);
    assign enter_o = new_key && (keycode == KEY_ENTER);
    assign up_o    = new_key && (keycode == KEY_UP);
    assign down_o  = new_key && (keycode == KEY_DOWN);

endmodule
`default_nettype wire

// File: rtl/match_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : match_state_ctrl
// Description : N-player Tron match controller: map menu, pause/start, crash
//               tracking, scoring, first-to-WINS_TO_MATCH match end.
//               Define MATCH_PAUSE_EN to allow pausing a running round.
// Revision    : 1.0 - initial release
// ============================================================================
module match_state_ctrl
    import tron_game_pkg::*;
#(
    parameter int NUM_PLAYERS   = 2,
    parameter int NUM_MAPS      = 4,
    parameter int WINS_TO_MATCH = 3,
    parameter int SCORE_W       = 4,
    localparam int MAP_W        = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1,
    localparam int WIN_W        = $clog2(NUM_PLAYERS)
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           Reset_Game,
    input  logic [7:0]                     keycode,
    input  logic [NUM_PLAYERS-1:0]         crash,
    output logic [2:0]                     game_state,
    output logic [MAP_W-1:0]               map_sel,
    output logic [2:0]                     screen_sel,
    output logic                           load_background,
    output logic                           round_active,
    output logic [NUM_PLAYERS-1:0]         alive,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [WIN_W-1:0]               winner,
    output logic                           winner_vld
);

    localparam logic [MAP_W-1:0]   MAP_LAST  = MAP_W'(NUM_MAPS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] WINS_C    = SCORE_W'(WINS_TO_MATCH);

    game_state_t                   state_q, state_d;
    screen_t                       screen_q, screen_d;
    logic [MAP_W-1:0]              map_q, map_d;
    logic [NUM_PLAYERS-1:0]        alive_q, alive_d;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d;
    logic [WIN_W-1:0]              winner_q, winner_d;
    logic                          win_vld_q, win_vld_d;
    logic                          load_q, load_d;
    logic                          active_q, active_d;

    logic                          key_enter, key_up, key_down;
    logic [NUM_PLAYERS-1:0]        alive_next;
    logic [2:0]                    survivors;
    logic [WIN_W-1:0]              win_idx;
    logic [SCORE_W-1:0]            win_score;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores_won;

    function automatic logic [2:0] popcount(input logic [NUM_PLAYERS-1:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            cnt = cnt + 3'(v[i]);
        end
        return cnt;
    endfunction

    function automatic logic [WIN_W-1:0] survivor_idx(input logic [NUM_PLAYERS-1:0] v);
        logic [WIN_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (v[i]) begin
                idx = WIN_W'(i);
            end
        end
        return idx;
    endfunction

    key_press_detect u_keys (
        .Clk        (Clk),
        .Reset      (Reset),
        .Reset_Game (Reset_Game),
        .keycode    (keycode),
        .enter_o    (key_enter),
        .up_o       (key_up),
        .down_o     (key_down)
    );

    always_comb begin
        state_d    = state_q;
        map_d      = map_q;
        alive_d    = alive_q;
        scores_d   = scores_q;
        winner_d   = winner_q;
        win_vld_d  = win_vld_q;
        load_d     = 1'b0;

        // Dead players' crash bits drop out through the AND with alive_q.
        alive_next = alive_q & ~crash;
        survivors  = popcount(alive_next);
        win_idx    = survivor_idx(alive_next);
        win_score  = '0;
        scores_won = scores_q;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (alive_next[i]) begin
                win_score = (scores_q[i*SCORE_W +: SCORE_W] == SCORE_MAX) ?
                            SCORE_MAX : scores_q[i*SCORE_W +: SCORE_W] + 1'b1;
                scores_won[i*SCORE_W +: SCORE_W] = win_score;
            end
        end

        case (state_q)
            MENU: begin
                if (key_up) begin
                    map_d = (map_q == MAP_LAST) ? '0 : map_q + 1'b1;
                end else if (key_down) begin
                    map_d = (map_q == '0) ? MAP_LAST : map_q - 1'b1;
                end else if (key_enter) begin
                    state_d  = ROUND_PAUSED;
                    scores_d = '0;
                    alive_d  = '1;
                    load_d   = 1'b1;
                end
            end
            ROUND_PAUSED: begin
                if (key_enter) begin
                    state_d = ROUND_STARTED;
                end
            end
            ROUND_STARTED: begin
                alive_d = alive_next;
                if (survivors == 3'd1) begin
                    scores_d  = scores_won;
                    winner_d  = win_idx;
                    win_vld_d = 1'b1;
                    load_d    = 1'b1;
                    state_d   = (win_score >= WINS_C) ? MATCH_OVER : ROUND_OVER;
                end else if (survivors == 3'd0) begin
                    win_vld_d = 1'b0;
                    load_d    = 1'b1;
                    state_d   = ROUND_OVER;
                end
`ifdef MATCH_PAUSE_EN
                else if (key_enter && ((alive_q & crash) == '0)) begin
                    state_d = ROUND_PAUSED;
                end
`else
`endif
            end
            ROUND_OVER: begin
                if (key_enter) begin
                    state_d   = ROUND_PAUSED;
                    alive_d   = '1;
                    win_vld_d = 1'b0;
                    load_d    = 1'b1;
                end
            end
            MATCH_OVER: begin
                if (key_enter) begin
                    state_d   = MENU;
                    scores_d  = '0;
                    alive_d   = '1;
                    win_vld_d = 1'b0;
                    load_d    = 1'b1;
                end
            end
            default: begin
                state_d = MENU;
            end
        endcase

        screen_d = screen_of(state_d);
        active_d = (state_d == ROUND_STARTED);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= MENU;
            screen_q  <= SCR_MENU;
            map_q     <= '0;
            alive_q   <= '1;
            scores_q  <= '0;
            winner_q  <= '0;
            win_vld_q <= 1'b0;
            load_q    <= 1'b0;
            active_q  <= 1'b0;
        end else if (Reset_Game) begin
            state_q   <= MENU;
            screen_q  <= SCR_MENU;
            map_q     <= '0;
            alive_q   <= '1;
            scores_q  <= '0;
            winner_q  <= '0;
            win_vld_q <= 1'b0;
            load_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            screen_q  <= screen_d;
            map_q     <= map_d;
            alive_q   <= alive_d;
            scores_q  <= scores_d;
            winner_q  <= winner_d;
            win_vld_q <= win_vld_d;
            load_q    <= load_d;
            active_q  <= active_d;
        end
    end

    assign game_state      = state_q;
    assign screen_sel      = screen_q;
    assign map_sel         = map_q;
    assign alive           = alive_q;
    assign scores          = scores_q;
    assign winner          = winner_q;
    assign winner_vld      = win_vld_q;
    assign load_background = load_q;
    assign round_active    = active_q;

endmodule
`default_nettype wire
